// File: rtl/bru_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bru_pkg
// Brief    : Opcode/func3 constants and counter limits for branch_resolve_bht.
// Revision : 1.0
// ============================================================================
package bru_pkg;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Weakly not-taken: MSB clear, all lower bits set.
  function automatic int ctr_reset_val(input int bits);
    return (1 << (bits - 1)) - 1;
  endfunction

  function automatic int ctr_max_val(input int bits);
    return (1 << bits) - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bru_cond_eval.sv
`default_nettype none
// ============================================================================
// Module   : bru_cond_eval
// Brief    : Combinational branch/jump direction and illegal-func3 decoder.
// Revision : 1.0
// ============================================================================
module bru_cond_eval
  import bru_pkg::*;
(
  input  logic       i_boj,
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_func3,
  input  logic       i_zero,
  input  logic       i_lt,
  input  logic       i_ltu,
  output logic       o_taken,
  output logic       o_illegal,
  output logic       o_cond_legal
);

  logic w_is_jump;

  assign w_is_jump = (i_opcode == OP_JAL) || (i_opcode == OP_JALR);

  always_comb begin
    o_taken      = 1'b0;
    o_illegal    = 1'b0;
    o_cond_legal = 1'b0;
    if (i_boj) begin
      if (w_is_jump) begin
        o_taken = 1'b1;
      end else begin
        o_cond_legal = 1'b1;
        case (i_func3)
          F3_BEQ:  o_taken = i_zero;
          F3_BNE:  o_taken = ~i_zero;
          F3_BLT:  o_taken = i_lt;
          F3_BGE:  o_taken = i_zero | ~i_lt;
          F3_BLTU: o_taken = i_ltu;
          F3_BGEU: o_taken = i_zero | ~i_ltu;
          default: begin
            o_illegal    = 1'b1;
            o_cond_legal = 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/branch_resolve_bht.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_bht
// Brief    : EX-stage branch resolution, saturating-counter BHT lookup for IF,
//            and registered mispredict flush. Define BRU_GSHARE_EN to XOR a
//            global history register into both table indices.
// Revision : 1.0
// ============================================================================
module branch_resolve_bht
  import bru_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CTR_BITS    = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_pred_taken,
  input  logic            ex_valid,
  input  logic            ex_boj,
  input  logic [6:0]      ex_opcode,
  input  logic [2:0]      ex_func3,
  input  logic            ex_zero,
  input  logic            ex_lt,
  input  logic            ex_ltu,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_pred_taken,
  output logic            ex_taken,
  output logic            ex_illegal,
  output logic            flush_o
);

  localparam int IDX = $clog2(BHT_ENTRIES);
  localparam logic [CTR_BITS-1:0] c_ctr_rst = CTR_BITS'(ctr_reset_val(CTR_BITS));
  localparam logic [CTR_BITS-1:0] c_ctr_max = CTR_BITS'(ctr_max_val(CTR_BITS));

  logic [CTR_BITS-1:0] r_bht [BHT_ENTRIES];
  logic                r_flush;

  logic [IDX-1:0]      w_if_idx;
  logic [IDX-1:0]      w_ex_idx;
  logic                w_cond_legal;
  logic                w_live;
  logic                w_upd;
  logic                w_mispredict;
  logic [CTR_BITS-1:0] w_ctr_cur;
  logic [CTR_BITS-1:0] w_ctr_nxt;
  logic                w_unused_pc;

  bru_cond_eval u_cond_eval (
    .i_boj        (ex_boj),
    .i_opcode     (ex_opcode),
    .i_func3      (ex_func3),
    .i_zero       (ex_zero),
    .i_lt         (ex_lt),
    .i_ltu        (ex_ltu),
    .o_taken      (ex_taken),
    .o_illegal    (ex_illegal),
    .o_cond_legal (w_cond_legal)
  );

  // The cycle right after a flush holds a wrong-path instruction.
  assign w_live       = ex_valid & ex_boj & ~r_flush;
  assign w_upd        = w_live & w_cond_legal;
  assign w_mispredict = w_live & (ex_taken != ex_pred_taken);

`ifdef BRU_GSHARE_EN
  logic [IDX-1:0] r_ghr;

  assign w_if_idx = if_pc[IDX+1:2] ^ r_ghr;
  assign w_ex_idx = ex_pc[IDX+1:2] ^ r_ghr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ghr <= '0;
    end else if (w_upd) begin
      r_ghr <= {r_ghr[IDX-2:0], ex_taken};
    end
  end
`else
  assign w_if_idx = if_pc[IDX+1:2];
  assign w_ex_idx = ex_pc[IDX+1:2];
`endif

  // Table read is ahead of the write, so a same-index update is not visible yet.
  assign if_pred_taken = r_bht[w_if_idx][CTR_BITS-1];
  assign w_ctr_cur     = r_bht[w_ex_idx];

  always_comb begin
    w_ctr_nxt = w_ctr_cur;
    if (ex_taken) begin
      if (w_ctr_cur != c_ctr_max) begin
        w_ctr_nxt = w_ctr_cur + CTR_BITS'(1);
      end
    end else if (w_ctr_cur != '0) begin
      w_ctr_nxt = w_ctr_cur - CTR_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        r_bht[i] <= c_ctr_rst;
      end
    end else if (w_upd) begin
      r_bht[w_ex_idx] <= w_ctr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flush <= 1'b0;
    end else begin
      r_flush <= w_mispredict;
    end
  end

  assign flush_o = r_flush;

  assign w_unused_pc = ^{if_pc[XLEN-1:IDX+2], if_pc[1:0], ex_pc[XLEN-1:IDX+2], ex_pc[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_bht.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_resolve_bht
// Brief    : Randomized and directed self-checking bench for branch_resolve_bht
//            against a behavioural predictor model.
// Revision : 1.0
// ============================================================================
module tb_branch_resolve_bht;
  import bru_pkg::*;

  localparam int ENT = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic        ex_valid;
  logic        ex_boj;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_func3;
  logic        ex_zero;
  logic        ex_lt;
  logic        ex_ltu;
  logic [31:0] ex_pc;
  logic        ex_pred_taken;
  logic        ex_taken;
  logic        ex_illegal;
  logic        flush_o;
  logic [31:0] op_a;
  logic [31:0] op_b;

  int          n_checks = 0;
  int          n_pass   = 0;

  int          m_ctr [ENT];
  bit          m_flush;
  logic [5:0]  m_ghr;

  assign ex_zero = (op_a == op_b);
  assign ex_lt   = ($signed(op_a) < $signed(op_b));
  assign ex_ltu  = (op_a < op_b);

  always #5 clk = ~clk;

  branch_resolve_bht dut (
    .clk           (clk),
    .rst           (rst),
    .if_pc         (if_pc),
    .if_pred_taken (if_pred_taken),
    .ex_valid      (ex_valid),
    .ex_boj        (ex_boj),
    .ex_opcode     (ex_opcode),
    .ex_func3      (ex_func3),
    .ex_zero       (ex_zero),
    .ex_lt         (ex_lt),
    .ex_ltu        (ex_ltu),
    .ex_pc         (ex_pc),
    .ex_pred_taken (ex_pred_taken),
    .ex_taken      (ex_taken),
    .ex_illegal    (ex_illegal),
    .flush_o       (flush_o)
  );

  function automatic int pidx(input logic [31:0] pc);
    return int'(pc[7:2] ^ m_ghr);
  endfunction

  function automatic bit m_pred(input logic [31:0] pc);
    return m_ctr[pidx(pc)] >= 2;
  endfunction

  function automatic bit exp_jump();
    return ex_boj && (ex_opcode == OP_JAL || ex_opcode == OP_JALR);
  endfunction

  function automatic bit exp_taken();
    if (!ex_boj) return 1'b0;
    if (exp_jump()) return 1'b1;
    case (ex_func3)
      3'd0:    return op_a == op_b;
      3'd1:    return op_a != op_b;
      3'd4:    return $signed(op_a) <  $signed(op_b);
      3'd5:    return $signed(op_a) >= $signed(op_b);
      3'd6:    return op_a <  op_b;
      3'd7:    return op_a >= op_b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit exp_illegal();
    return ex_boj && !exp_jump() && (ex_func3 == 3'd2 || ex_func3 == 3'd3);
  endfunction

  task automatic set_ex(input bit v, input bit boj, input logic [6:0] op, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc, input bit pred);
    ex_valid = v; ex_boj = boj; ex_opcode = op; ex_func3 = f3;
    op_a = a; op_b = b; ex_pc = pc; ex_pred_taken = pred;
  endtask

  task automatic idle();
    set_ex(1'b0, 1'b0, 7'h13, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0);
  endtask

  // Advance one clock and apply the architectural rules to the model.
  task automatic tick();
    bit tk, ill, jmp, live, mp;
    int ui;
    jmp  = exp_jump();
    tk   = exp_taken();
    ill  = exp_illegal();
    live = ex_valid && ex_boj && !m_flush;
    mp   = live && (tk != ex_pred_taken);
    ui   = pidx(ex_pc);
    @(posedge clk);
    #1;
    if (rst) begin
      for (int i = 0; i < ENT; i++) m_ctr[i] = 1;
      m_flush = 1'b0;
      m_ghr   = '0;
    end else begin
      if (live && !jmp && !ill) begin
        if (tk && m_ctr[ui] < 3) m_ctr[ui]++;
        else if (!tk && m_ctr[ui] > 0) m_ctr[ui]--;
`ifdef BRU_GSHARE_EN
        m_ghr = {m_ghr[4:0], tk};
`endif
      end
      m_flush = mp;
    end
  endtask

  task automatic probe_table(input string tag);
    idle();
    for (int e = 0; e < ENT; e++) begin
      if_pc = {$urandom, 8'h00} | {24'd0, 6'(e) ^ m_ghr, 2'(($urandom))};
      #1;
      n_checks++;
      if (if_pred_taken !== (m_ctr[e] >= 2))
        $display("FAIL probe_%s entry %0d: got %b want %b", tag, e, if_pred_taken, (m_ctr[e] >= 2));
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); if_pc = 32'h40;
    tick(); tick();
    rst = 1'b0;
    if_pc = $urandom;
    #1;
    n_checks++;
    if (if_pred_taken !== 1'b0) $display("FAIL reset_pred: got %b want 0", if_pred_taken);
    else n_pass++;
    n_checks++;
    if (flush_o !== 1'b0) $display("FAIL reset_flush: got %b want 0", flush_o);
    else n_pass++;
    // Mispredicting taken BEQ under reset: neither flush nor update may survive.
    rst = 1'b1;
    set_ex(1'b1, 1'b1, OP_BRANCH, F3_BEQ, 32'd5, 32'd5, 32'h40, 1'b0);
    tick();
    rst = 1'b0; idle(); if_pc = 32'h40;
    #1;
    n_checks++;
    if (flush_o !== 1'b0) $display("FAIL reset_mid_flush: got %b want 0", flush_o);
    else n_pass++;
    n_checks++;
    if (if_pred_taken !== 1'b0) $display("FAIL reset_mid_noupd: got %b want 0", if_pred_taken);
    else n_pass++;
  endtask

  task automatic test_beq_flush();
    idle(); tick();
    set_ex(1'b1, 1'b1, OP_BRANCH, F3_BEQ, 32'd7, 32'd7, 32'h10, 1'b0);
    #1;
    n_checks++;
    if (ex_taken !== 1'b1) $display("FAIL beq_taken: got %b want 1", ex_taken);
    else n_pass++;
    tick();
    idle();
    n_checks++;
    if (flush_o !== 1'b1) $display("FAIL beq_flush_on: got %b want 1", flush_o);
    else n_pass++;
    tick();
    n_checks++;
    if (flush_o !== 1'b0) $display("FAIL beq_flush_1cyc: got %b want 0", flush_o);
    else n_pass++;
    set_ex(1'b1, 1'b1, OP_BRANCH, F3_BEQ, 32'd7, 32'd8, 32'h10, 1'b0);
    #1;
    n_checks++;
    if (ex_taken !== 1'b0) $display("FAIL beq_nt_taken: got %b want 0", ex_taken);
    else n_pass++;
    tick();
    n_checks++;
    if (flush_o !== 1'b0) $display("FAIL beq_nt_flush: got %b want 0", flush_o);
    else n_pass++;
  endtask

  task automatic test_counter_saturate();
    bit lit [6];
    lit[0] = 1; lit[1] = 1; lit[2] = 1; lit[3] = 1; lit[4] = 1; lit[5] = 0;
    idle(); tick();
    for (int k = 0; k < 6; k++) begin
      // Four taken BNEs, then two not-taken.
      set_ex(1'b1, 1'b1, OP_BRANCH, F3_BNE, 32'd1, (k < 4) ? 32'd2 : 32'd1, 32'h20, m_pred(32'h20));
      #1;
      n_checks++;
      if (ex_taken !== (k < 4)) $display("FAIL ctr_taken k=%0d: got %b want %b", k, ex_taken, (k < 4));
      else n_pass++;
      tick();
      idle(); tick();
      if_pc = 32'h20;
      #1;
      n_checks++;
      if (if_pred_taken !== m_pred(32'h20))
        $display("FAIL ctr_pred_model k=%0d: got %b want %b", k, if_pred_taken, m_pred(32'h20));
      else n_pass++;
`ifndef BRU_GSHARE_EN
      n_checks++;
      if (if_pred_taken !== lit[k]) $display("FAIL ctr_pred_lit k=%0d: got %b want %b", k, if_pred_taken, lit[k]);
      else n_pass++;
`endif
    end
  endtask

  task automatic test_jalr_illegal();
    idle(); tick();
    set_ex(1'b1, 1'b1, OP_BRANCH, F3_BEQ, 32'd3, 32'd3, 32'h30, m_pred(32'h30));
    tick(); idle(); tick();
    set_ex(1'b1, 1'b1, OP_JALR, 3'd0, 32'd1, 32'd2, 32'h30, 1'b0);
    #1;
    n_checks++;
    if (ex_taken !== 1'b1 || ex_illegal !== 1'b0)
      $display("FAIL jalr_resolve: got taken=%b ill=%b want taken=1 ill=0", ex_taken, ex_illegal);
    else n_pass++;
    tick();
    idle();
    n_checks++;
    if (flush_o !== 1'b1) $display("FAIL jalr_flush: got %b want 1", flush_o);
    else n_pass++;
    tick();
    for (int p = 0; p < 2; p++) begin
      set_ex(1'b1, 1'b1, OP_BRANCH, 3'd3, 32'd1, 32'd2, 32'h30, p[0]);
      if_pc = 32'h30;
      #1;
      n_checks++;
      if (ex_illegal !== 1'b1 || ex_taken !== 1'b0)
        $display("FAIL illegal_resolve: got taken=%b ill=%b want taken=0 ill=1", ex_taken, ex_illegal);
      else n_pass++;
      tick();
      idle();
      n_checks++;
      if (flush_o !== m_flush) $display("FAIL illegal_flush p=%0d: got %b want %b", p, flush_o, m_flush);
      else n_pass++;
      tick();
      if_pc = 32'h30;
      #1;
      n_checks++;
      if (if_pred_taken !== m_pred(32'h30))
        $display("FAIL illegal_noupd p=%0d: got %b want %b", p, if_pred_taken, m_pred(32'h30));
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    idle(); tick();
    set_ex(1'b1, 1'b1, OP_BRANCH, F3_BEQ, 32'd9, 32'd9, 32'h44, 1'b0);
    tick();
    set_ex(1'b1, 1'b1, OP_BRANCH, F3_BEQ, 32'd9, 32'd9, 32'h48, 1'b0);
    n_checks++;
    if (flush_o !== 1'b1) $display("FAIL b2b_first_flush: got %b want 1", flush_o);
    else n_pass++;
    tick();
    idle();
    n_checks++;
    if (flush_o !== 1'b0) $display("FAIL b2b_second_flush: got %b want 0", flush_o);
    else n_pass++;
    if_pc = 32'h48;
    #1;
    n_checks++;
    if (if_pred_taken !== m_pred(32'h48))
      $display("FAIL b2b_noupd: got %b want %b", if_pred_taken, m_pred(32'h48));
    else n_pass++;
  endtask

  task automatic test_read_before_write();
    bit old_pred;
    idle(); tick();
    if_pc = 32'h80;
    old_pred = m_pred(32'h80);
    set_ex(1'b1, 1'b1, OP_BRANCH, F3_BGEU, 32'd4, 32'd4, 32'h80, 1'b1);
    #1;
    n_checks++;
    if (if_pred_taken !== old_pred) $display("FAIL rbw_old: got %b want %b", if_pred_taken, old_pred);
    else n_pass++;
    tick();
    idle();
    #1;
    n_checks++;
    if (if_pred_taken !== m_pred(32'h80)) $display("FAIL rbw_new: got %b want %b", if_pred_taken, m_pred(32'h80));
    else n_pass++;
    probe_table("directed");
  endtask

`ifdef BRU_GSHARE_EN
  task automatic test_gshare();
    idle(); tick();
    for (int k = 0; k < 4; k++) begin
      set_ex(1'b1, 1'b1, OP_BRANCH, F3_BLT, (k % 2 == 0) ? 32'hFFFF_FFFF : 32'd5, 32'd1, 32'h200, m_pred(32'h200));
      if_pc = 32'h200;
      #1;
      n_checks++;
      if (if_pred_taken !== m_pred(32'h200))
        $display("FAIL gshare_pred k=%0d: got %b want %b", k, if_pred_taken, m_pred(32'h200));
      else n_pass++;
      tick(); idle(); tick();
    end
    probe_table("gshare");
  endtask
`endif

  function automatic logic [31:0] pick_val(input int s);
    case (s)
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      default: return 32'h8000_0000;
    endcase
  endfunction

  function automatic logic [6:0] pick_op(input int s);
    case (s)
      0:       return OP_JAL;
      1:       return OP_JALR;
      2:       return 7'h33;
      default: return OP_BRANCH;
    endcase
  endfunction

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      set_ex($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, pick_op($urandom_range(0, 5)),
             3'($urandom), pick_val($urandom_range(0, 3)), pick_val($urandom_range(0, 3)),
             {$urandom} & 32'h0000_003C, 1'($urandom));
      if_pc = ({$urandom} & 32'h0000_003F) | 32'h1000;
      #1;
      n_checks++;
      if (ex_taken !== exp_taken() || ex_illegal !== exp_illegal())
        $display("FAIL rand_resolve c=%0d: got taken=%b ill=%b want taken=%b ill=%b",
                 c, ex_taken, ex_illegal, exp_taken(), exp_illegal());
      else n_pass++;
      n_checks++;
      if (if_pred_taken !== m_pred(if_pc))
        $display("FAIL rand_pred c=%0d: got %b want %b", c, if_pred_taken, m_pred(if_pc));
      else n_pass++;
      tick();
      n_checks++;
      if (flush_o !== m_flush) $display("FAIL rand_flush c=%0d: got %b want %b", c, flush_o, m_flush);
      else n_pass++;
    end
    rst = 1'b0;
    probe_table("random");
  endtask

  initial begin
    rst = 1'b0;
    idle();
    if_pc   = '0;
    m_flush = 1'b0;
    m_ghr   = '0;
    for (int i = 0; i < ENT; i++) m_ctr[i] = 1;
    test_reset();
    test_beq_flush();
    test_counter_saturate();
    test_jalr_illegal();
    test_back_to_back();
    test_read_before_write();
`ifdef BRU_GSHARE_EN
    test_gshare();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
